// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin decode arbiter.
// Holds the FSM state enum, the rotate-priority pick function and the select decoder.
package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef struct packed {
    logic             any;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Rotating right by ptr puts requester ptr at bit 0, so the lowest set bit is
  // the next in round-robin order; adding ptr back wraps naturally in IDX_W bits.
  function automatic pick_t rotate_pick(input logic [N_REQ-1:0] req,
                                        input logic [IDX_W-1:0] ptr);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    pick_t              p;
    dbl   = {req, req};
    rot   = N_REQ'(dbl >> ptr);
    p.any = |req;
    p.idx = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rot[j]) p.idx = IDX_W'(j) + ptr;
    end
    return p;
  endfunction

  function automatic logic [N_REQ-1:0] decode_sel(input logic [IDX_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin winner search starting at the priority pointer.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  pick_t w_pick;

  assign w_pick = rotate_pick(req, ptr);
  assign any    = w_pick.any;
  assign idx    = w_pick.idx;

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter driving a shared 3-to-8 select decoder; grants are held
// until done, withdrawal or hold timeout, with one idle cycle between grants.
module rr_decode_arbiter
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_HOLD - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [CNT_W-1:0] r_cnt;
  logic [N_REQ-1:0] r_gnt;
  logic             r_gnt_valid;
  logic             r_timeout;

  logic             w_any;
  logic [IDX_W-1:0] w_idx;
  logic             w_owner_release;
  logic             w_hold_expired;

  rr_pick u_pick (
    .req (req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  // An owner-initiated release outranks the timeout, so both together never pulse timeout.
  assign w_owner_release = done || !req[r_gnt_idx];
  assign w_hold_expired  = (r_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gnt_idx   <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state     <= BUSY;
            r_gnt_idx   <= w_idx;
            r_gnt       <= decode_sel(w_idx);
            r_gnt_valid <= 1'b1;
            r_cnt       <= '0;
          end
        end
        BUSY: begin
          if (w_owner_release || w_hold_expired) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= r_gnt_idx + IDX_W'(1);
            r_timeout   <= !w_owner_release;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule
